// File: rtl/ipm_mask.sv
// ---------------------------------------------------------------------------
// ipm_mask -- Inner-Product-Masking encoder over GF(2^8) (AES polynomial 0x11B)
//
// Splits one secret byte into an N-share vector (M0, M1, ..., M(N-1)) such
// that XOR_k gfmul(L[k], Mk) == secret, with L = {1, 27, 250, 188}.
// The shares M1..M(N-1) are the fresh random bytes. The block computes
// M0 = secret ^ XOR_{k>=1} gfmul(L[k], Mk) by iterating one shared GF
// multiplier over N-1 accumulate cycles. The output vector is in the operand
// format expected by the downstream IPM multiplier stage.
//
// Parameters:
//   N          number of shares, legal range 2..4
//   LFSR_SEED  initial state of the internal LFSR (optional feature only)
//   WIDTH      N*8, width of the share vector (derived)
//
// Ports:
//   clk_i      clock
//   reset_i    asynchronous active-high reset
//   start_i    request pulse, accepted only while idle
//   secret_i   secret byte to mask
//   rnd_i      random shares M1..M(N-1), M1 in the MSBs
//   busy_o     high whenever the encoder is not idle
//   result_o   masked vector, share 0 in the MSBs, held until the next result
//   valid_o    one-cycle pulse, result_o updated in the same cycle
//
// Optional feature (macro IPM_MASK_LFSR_EN):
//   When defined, a 32-bit Galois LFSR (taps 0x80200003) seeded with
//   LFSR_SEED free-runs every cycle and supplies the random shares on
//   accept; rnd_i is then ignored but kept on the interface.
//
// Timing: start_i sampled at edge 0 -> ACC during cycles 1..N-1 -> valid_o
// and the new result_o during cycle N -> idle again in cycle N+1.
// ---------------------------------------------------------------------------
module ipm_mask #(
  parameter int          N         = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
  localparam int         WIDTH     = N * 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [7:0]       secret_i,
  input  logic [WIDTH-9:0] rnd_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o
);

  // Share index counter width: enough to hold N-1, never narrower than 1 bit.
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // GF(2^8) helpers
  // -------------------------------------------------------------------------

  // Shift-and-add multiply, reducing by x^8 = x^4 + x^3 + x + 1 (0x1B)
  // after every doubling of the running multiplicand.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] x;
    prod = 8'h00;
    x    = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        prod = prod ^ x;
      end
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return prod;
  endfunction

  // Public IPM coefficient vector L. Entry 0 is unity so share 0 enters the
  // inner product unchanged.
  function automatic logic [7:0] l_coef(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = 8'h01;
      2'd1:    c = 8'h1B;
      2'd2:    c = 8'hFA;
      default: c = 8'hBC;
    endcase
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [KW-1:0]    k_reg;
  logic [7:0]       acc_reg;
  logic [7:0]       secret_reg;
  logic [WIDTH-9:0] rnd_reg;
  logic [WIDTH-1:0] result_reg;

  // Source of the random shares latched on accept.
  logic [WIDTH-9:0] rnd_src;

`ifdef IPM_MASK_LFSR_EN
  // Galois LFSR: shift right, fold the tap mask in when the bit shifted out
  // is 1. A non-zero seed can never reach the all-zero lock-up state.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [31:0] lfsr_reg;
  logic [31:0] lfsr_next;
  logic        unused_rnd;

  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[31:1]};
    if (lfsr_reg[0]) begin
      lfsr_next = lfsr_next ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign rnd_src    = lfsr_reg[WIDTH-9:0];
  // rnd_i stays on the port list for interface compatibility only.
  assign unused_rnd = ^rnd_i;
`else
  logic unused_seed;

  assign rnd_src     = rnd_i;
  // The seed only matters when the LFSR is built in.
  assign unused_seed = ^LFSR_SEED;
`endif

  // -------------------------------------------------------------------------
  // Byte view of the latched random shares: rnd_byte[j] holds share j+1.
  // -------------------------------------------------------------------------
  logic [7:0] rnd_byte [N-1];

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_rnd_byte
      assign rnd_byte[gi] = rnd_reg[WIDTH-9-8*gi -: 8];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Shared multiplier: both operands come from registers only (k_reg and
  // rnd_reg), so there is no combinational path from any input to the
  // multiplier or to the outputs.
  // -------------------------------------------------------------------------
  logic [7:0] rnd_sel;
  logic [1:0] l_idx;
  logic [7:0] mul_out;
  logic [7:0] acc_next;
  logic       last_k;

  always_comb begin
    rnd_sel = 8'h00;
    for (int j = 0; j < N - 1; j++) begin
      if (k_reg == KW'(j + 1)) begin
        rnd_sel = rnd_byte[j];
      end
    end
  end

  assign l_idx    = 2'(k_reg);
  assign mul_out  = gf_mul(l_coef(l_idx), rnd_sel);
  assign acc_next = acc_reg ^ mul_out;
  assign last_k   = (k_reg == KW'(N - 1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = ACC;
        end
      end
      ACC: begin
        if (last_k) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Requests seen here are dropped; the next one is taken in IDLE.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy_o  = (state_reg != IDLE);
    valid_o = (state_reg == DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      k_reg      <= '0;
      acc_reg    <= 8'h00;
      secret_reg <= 8'h00;
      rnd_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            secret_reg <= secret_i;
            rnd_reg    <= rnd_src;
            acc_reg    <= 8'h00;
            k_reg      <= KW'(1);
          end
        end
        ACC: begin
          acc_reg <= acc_next;
          if (last_k) begin
            // Load the result on the edge that enters DONE so result_o and
            // valid_o change together; k parks at 0 instead of wrapping.
            result_reg <= {secret_reg ^ acc_next, rnd_reg};
            k_reg      <= '0;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        default: begin
          // DONE: all operands and the result simply hold.
        end
      endcase
    end
  end

  assign result_o = result_reg;

endmodule
